// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: rotating-pointer find-first-set over N requests, registered one-hot grant.
// Optional GRANT_TIMEOUT_EN macro adds a hold counter that force-releases long grants.
module rr_onehot_arbiter #(
    parameter int unsigned N       = 32,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
`ifdef GRANT_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [N-1:0]     owner_oh_c;
    logic             owner_req_c;
    logic             force_c;
    logic [N-1:0]     higher_mask_c;
    logic [N-1:0]     cand_c;
    logic [N-1:0]     masked_c;
    logic             win_any_c;
    logic [IDX_W-1:0] win_idx_c;
    logic [N-1:0]     win_oh_c;

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] ffs_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign owner_oh_c  = N'(1) << ptr_q;
    assign owner_req_c = |(req & owner_oh_c);

`ifdef GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    assign force_c = (state_q == S_GRANT) && owner_req_c && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout = tmo_q;
`else
    assign force_c = 1'b0;
`endif

    // Owner bit is always excluded while granted, so a forced release cannot re-pick it.
    always_comb begin
        higher_mask_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            higher_mask_c[i] = (i > 32'(ptr_q));
        end
        cand_c    = (state_q == S_GRANT) ? (req & ~owner_oh_c) : req;
        masked_c  = cand_c & higher_mask_c;
        win_any_c = |cand_c;
        win_idx_c = (|masked_c) ? ffs_idx(masked_c) : ffs_idx(cand_c);
        win_oh_c  = N'(1) << win_idx_c;
    end

    // Next-state: hold while owner requests, otherwise rearbitrate in the same cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef GRANT_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        if ((state_q == S_GRANT) && owner_req_c && !force_c) begin
`ifdef GRANT_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
            tmo_d = force_c;
`endif
            if (win_any_c) begin
                state_d = S_GRANT;
                ptr_d   = win_idx_c;
                gnt_d   = win_oh_c;
                idx_d   = win_idx_c;
                valid_d = 1'b1;
`ifdef GRANT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end else begin
                state_d = S_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IDX_W'(N - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
`ifdef GRANT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule
